// File: rtl/sal_rd_resp_gen_if.sv
// sal_rd_resp_gen_if
//   Bundles the read-command, DFI read-data and AXI R channel signals of the
//   SAL read-response generator.
//   slave  : the response generator side (consumes cmd/dfi/rready, drives R).
//   master : the environment side (scheduler, PHY capture, AXI interconnect).
interface sal_rd_resp_gen_if #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DATA_DEPTH = 16
);
    localparam int unsigned FREE_WIDTH = $clog2(DATA_DEPTH + 1);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  dfi_rddata_valid;
    logic [DATA_WIDTH-1:0] dfi_rddata;
    logic [FREE_WIDTH-1:0] data_free;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  overflow;

    modport slave (
        input  cmd_valid, cmd_id, cmd_len, dfi_rddata_valid, dfi_rddata, rready,
        output cmd_ready, data_free, rvalid, rid, rdata, rresp, rlast, overflow
    );

    modport master (
        output cmd_valid, cmd_id, cmd_len, dfi_rddata_valid, dfi_rddata, rready,
        input  cmd_ready, data_free, rvalid, rid, rdata, rresp, rlast, overflow
    );
endinterface

// File: rtl/sal_rd_resp_gen.sv
// sal_rd_resp_gen
//   Read-response generator: records {id, len} of each issued read command,
//   buffers returning DFI read beats, and emits them in issue order on the
//   AXI R channel with rid/rlast.
// Ports:
//   clk, rst_n : controller clock, asynchronous active-low reset.
//   bus        : sal_rd_resp_gen_if.slave (cmd push, DFI beats, data_free,
//                AXI R channel, sticky overflow).
// Build option:
//   SAL_RDRESP_OUT_REG_EN : registers the R channel through a 2-entry skid
//                           buffer (latency +1, full throughput kept).
module sal_rd_resp_gen #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned DATA_DEPTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    sal_rd_resp_gen_if.slave bus
);
    localparam int unsigned CAW = $clog2(CMD_DEPTH);
    localparam int unsigned DAW = $clog2(DATA_DEPTH);
    localparam int unsigned FW  = $clog2(DATA_DEPTH + 1);

    // Storage (not reset)
    logic [ID_WIDTH-1:0]   cmd_id_mem  [CMD_DEPTH];
    logic [LEN_WIDTH-1:0]  cmd_len_mem [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem    [DATA_DEPTH];

    logic [CAW:0]          cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
    logic [DAW:0]          data_wptr_q, data_wptr_d, data_rptr_q, data_rptr_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  overflow_q, overflow_d;

    logic                  cmd_full, cmd_empty, data_full, data_empty;
    logic                  cmd_push, cmd_pop, data_push;
    logic                  int_valid, int_pop, int_last;
    logic [ID_WIDTH-1:0]   head_id;
    logic [LEN_WIDTH-1:0]  head_len;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DAW:0]          data_occ;

    // MSB-differs / rest-equal full detection on depth+1-bit pointers
    assign cmd_empty  = (cmd_wptr_q == cmd_rptr_q);
    assign cmd_full   = (cmd_wptr_q[CAW] != cmd_rptr_q[CAW]) &&
                        (cmd_wptr_q[CAW-1:0] == cmd_rptr_q[CAW-1:0]);
    assign data_empty = (data_wptr_q == data_rptr_q);
    assign data_full  = (data_wptr_q[DAW] != data_rptr_q[DAW]) &&
                        (data_wptr_q[DAW-1:0] == data_rptr_q[DAW-1:0]);

    assign head_id   = cmd_id_mem[cmd_rptr_q[CAW-1:0]];
    assign head_len  = cmd_len_mem[cmd_rptr_q[CAW-1:0]];
    assign head_data = data_mem[data_rptr_q[DAW-1:0]];

    assign int_valid = !data_empty && !cmd_empty;
    assign int_last  = (beat_cnt_q == head_len);

    // A full command FIFO refuses the push even if it pops this cycle
    assign cmd_push  = bus.cmd_valid && !cmd_full;
    assign cmd_pop   = int_pop && int_last;
    // A full data FIFO may still accept a beat when its head leaves this cycle
    assign data_push = bus.dfi_rddata_valid && (!data_full || int_pop);

    assign data_occ      = data_wptr_q - data_rptr_q;
    assign bus.data_free = FW'(DATA_DEPTH) - FW'(data_occ);
    assign bus.cmd_ready = !cmd_full;
    assign bus.overflow  = overflow_q;
    assign bus.rresp     = 2'b00;

    always_comb begin
        cmd_wptr_d  = cmd_wptr_q  + (CAW+1)'(cmd_push);
        cmd_rptr_d  = cmd_rptr_q  + (CAW+1)'(cmd_pop);
        data_wptr_d = data_wptr_q + (DAW+1)'(data_push);
        data_rptr_d = data_rptr_q + (DAW+1)'(int_pop);
        beat_cnt_d  = beat_cnt_q;
        if (int_pop) begin
            beat_cnt_d = int_last ? '0 : beat_cnt_q + 1'b1;
        end
        overflow_d = overflow_q || (bus.dfi_rddata_valid && !data_push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wptr_q  <= '0;
            cmd_rptr_q  <= '0;
            data_wptr_q <= '0;
            data_rptr_q <= '0;
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            cmd_wptr_q  <= cmd_wptr_d;
            cmd_rptr_q  <= cmd_rptr_d;
            data_wptr_q <= data_wptr_d;
            data_rptr_q <= data_rptr_d;
            beat_cnt_q  <= beat_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_id_mem[cmd_wptr_q[CAW-1:0]]  <= bus.cmd_id;
            cmd_len_mem[cmd_wptr_q[CAW-1:0]] <= bus.cmd_len;
        end
        if (data_push) begin
            data_mem[data_wptr_q[DAW-1:0]] <= bus.dfi_rddata;
        end
    end

`ifdef SAL_RDRESP_OUT_REG_EN
    localparam int unsigned EW = ID_WIDTH + DATA_WIDTH + 1;

    logic [EW-1:0] ent0_q, ent0_d, ent1_q, ent1_d, ent_in;
    logic [1:0]    cnt_q, cnt_d;
    logic          rvalid_q, rvalid_d;
    logic          out_pop;

    assign ent_in  = {head_id, head_data, int_last};
    assign int_pop = int_valid && (cnt_q != 2'd2);
    assign out_pop = rvalid_q && bus.rready;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (out_pop) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
        end
        if (int_pop) begin
            if (cnt_d == 2'd0) begin
                ent0_d = ent_in;
            end else begin
                ent1_d = ent_in;
            end
            cnt_d = cnt_d + 2'd1;
        end
        // Empty output stage is zeroed so the flops alone present 0s
        if (cnt_d == 2'd0) begin
            ent0_d = '0;
        end
        rvalid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.rvalid = rvalid_q;
    assign {bus.rid, bus.rdata, bus.rlast} = ent0_q;
`else
    assign int_pop    = int_valid && bus.rready;
    assign bus.rvalid = int_valid;
    assign bus.rid    = int_valid ? head_id   : '0;
    assign bus.rdata  = int_valid ? head_data : '0;
    assign bus.rlast  = int_valid && int_last;
`endif
endmodule
